game_session_seq: RTL and testbench
===================================

Name: game_session_seq

Overview:
- Parametrised session sequencer for the memory-game top level.
- Owns the post-reset input block window, the boot and "new game" shuffle handshake with the deck shuffler, the soft-reset pulse to the game FSM and timer, and the turn-timer start pulse.
- Generalises the fixed inline new-game logic with the following additions:
  - configurable block, reset and settle lengths;
  - N gated button channels;
  - a one-deep pending new-game request;
  - a shuffle watchdog with a sticky timeout flag;
  - a games-played counter.

Parameters:
- N_BTN, 2: number of one-pulse button channels that are gated.
- BLOCK_CYCLES, 500000: input block window after rst_n release, in clk cycles (>=1).
- BOOT_SHUFFLE, 1: 1 = run a shuffle automatically when the block window ends; 0 = go straight to IDLE.
- SOFT_RST_CYCLES, 3: cycles that rst_game_n_o is held low (>=1).
- POST_RST_CYCLES, 2: settle cycles between soft reset and timer start (0 = the WAIT state is skipped).
- SHUF_TIMEOUT, 1024: max cycles in SHUF before the watchdog fires (>=2).
- CNT_W, 8: width of the games-played counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_pulse_i  in  N_BTN  debounced one-cycle button pulses
- newgame_i  in  1  debounced one-cycle "new game" pulse
- shuf_busy_i  in  1  shuffler busy
- shuf_done_i  in  1  shuffler done pulse
- shuf_start_o  out  1  one-cycle shuffle start
- rst_game_n_o  out  1  soft reset to game FSM/timer, active low
- btn_pulse_o  out  N_BTN  gated button pulses
- start_timer_o  out  1  one-cycle turn-timer start
- ready_o  out  1  1 in IDLE
- timeout_o  out  1  sticky shuffle-watchdog flag
- games_o  out  CNT_W  completed new-game sequences, saturating

Behaviour:
- Reset (rst_n low, async) sets:
  - state BLOCK, all counters 0, pending 0;
  - shuf_start_o=0, rst_game_n_o=1, btn_pulse_o=0, start_timer_o=0, ready_o=0, timeout_o=0, games_o=0.
- All state and outputs are registered, except btn_pulse_o = btn_pulse_i & {N_BTN{ready_o}} (combinational AND with the registered ready).
- BLOCK:
  - Counts 0..BLOCK_CYCLES-1. newgame_i and buttons are ignored (not latched).
  - At terminal count: next state SHUF if BOOT_SHUFFLE=1, else IDLE.
- IDLE:
  - ready_o=1.
  - newgame_i or pending, with shuf_busy_i=0: next state SHUF and pending is cleared.
  - Same conditions with shuf_busy_i=1: stay in IDLE and set pending.
  - A button pulse coincident with newgame_i in IDLE is still forwarded that cycle.
- SHUF:
  - shuf_start_o=1 in the first SHUF cycle only. The watchdog counter starts at 0 on entry.
  - shuf_done_i=1 (accepted in any SHUF cycle, including the first): next state RST, reset counter loaded.
  - Watchdog reaches SHUF_TIMEOUT-1 without done: timeout_o <= 1, next state RST. The game keeps its previous layout.
  - shuf_done_i outside SHUF is ignored.
- RST: rst_game_n_o=0 for exactly SOFT_RST_CYCLES consecutive cycles, then WAIT (or START if POST_RST_CYCLES=0).
- WAIT: exactly POST_RST_CYCLES cycles, all outputs idle, then START.
- START:
  - One cycle with start_timer_o=1; games_o increments, saturating at all ones.
  - Next state SHUF if pending=1 (pending cleared), else IDLE.
  - pending set by shuf_busy_i in IDLE still waits for busy low.
- Pending request: newgame_i in SHUF, RST, WAIT or START sets pending (one deep; extra presses collapse into it). newgame_i in the same cycle as the START exit is honoured.
- Latency, for newgame_i at cycle k in IDLE with shuf_busy_i low:
  - shuf_start_o at k+1;
  - for done at cycle d: rst_game_n_o low over d+1..d+SOFT_RST_CYCLES;
  - start_timer_o at d+SOFT_RST_CYCLES+POST_RST_CYCLES+1;
  - ready_o at the following cycle.
- timeout_o: cleared only by rst_n.
- rst_n asserted mid-sequence: everything returns to BLOCK immediately, including rst_game_n_o=1. The global reset covers the game.

Test Plan (BLOCK_CYCLES=8, SOFT_RST_CYCLES=3, POST_RST_CYCLES=2, SHUF_TIMEOUT=16, BOOT_SHUFFLE=1):
- Release rst_n at cycle 0; btn_pulse_i=2'b11 and newgame_i pulsed during cycles 0-7:
  - btn_pulse_o stays 0;
  - shuf_start_o=1 at cycle 8;
  - no extra shuffle from the ignored newgame.
- Boot shuffle, shuf_done_i at cycle 12:
  - rst_game_n_o low over cycles 13-15;
  - start_timer_o at cycle 18;
  - ready_o=1 and games_o=1 at cycle 19.
- In IDLE, newgame_i at cycle k with btn_pulse_i=2'b01 in the same cycle:
  - btn_pulse_o=2'b01 at k;
  - shuf_start_o at k+1;
  - after done, games_o=2.
- newgame_i pulsed three times during RST:
  - after START, SHUF is re-entered directly (no IDLE cycle);
  - exactly one extra shuf_start_o;
  - games_o ends at +2.
- Never assert shuf_done_i:
  - timeout_o=1 after 16 SHUF cycles;
  - RST/WAIT/START still run;
  - timeout_o stays 1 through the next successful game.
- With CNT_W=2, run 5 games: games_o saturates at 3. Pulse rst_n low during WAIT: all outputs return to reset values at once.

Source files
------------

// File: rtl/game_session_seq.sv
// ============================================================================
// Module      : game_session_seq
// Description : Session sequencer for the memory-game top level. Holds off
//               the buttons after power-up, runs the boot and new-game
//               shuffle handshake with the deck shuffler, pulses the soft
//               reset to the game FSM/timer, then fires the turn-timer start.
//               Adds a one-deep pending new-game request, a shuffle watchdog
//               with a sticky timeout flag and a saturating games counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_session_seq #(
    parameter int N_BTN           = 2,
    parameter int BLOCK_CYCLES    = 500000,
    parameter int BOOT_SHUFFLE    = 1,
    parameter int SOFT_RST_CYCLES = 3,
    parameter int POST_RST_CYCLES = 2,
    parameter int SHUF_TIMEOUT    = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_pulse_i,
    input  logic             newgame_i,
    input  logic             shuf_busy_i,
    input  logic             shuf_done_i,
    output logic             shuf_start_o,
    output logic             rst_game_n_o,
    output logic [N_BTN-1:0] btn_pulse_o,
    output logic             start_timer_o,
    output logic             ready_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] games_o
);

    // One shared down-the-line counter serves every timed state, so it is
    // sized for the longest of the windows it has to cover.
    localparam int c_MAX_A = (BLOCK_CYCLES > SHUF_TIMEOUT) ? BLOCK_CYCLES : SHUF_TIMEOUT;
    localparam int c_MAX_B = (SOFT_RST_CYCLES > POST_RST_CYCLES) ? SOFT_RST_CYCLES : POST_RST_CYCLES;
    localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CW    = $clog2(c_MAX + 1);

    // Terminal counts; the WAIT terminal is clamped so a zero-length settle
    // does not underflow (the state is never entered in that case).
    localparam int c_POST_M1 = (POST_RST_CYCLES > 0) ? (POST_RST_CYCLES - 1) : 0;

    localparam logic [c_CW-1:0] c_BLOCK_LAST = c_CW'(BLOCK_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TO_LAST    = c_CW'(SHUF_TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_RST_LAST   = c_CW'(SOFT_RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_POST_LAST  = c_CW'(c_POST_M1);
    localparam logic [CNT_W-1:0] c_GAMES_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_BLOCK = 3'd0,
        S_IDLE  = 3'd1,
        S_SHUF  = 3'd2,
        S_RST   = 3'd3,
        S_WAIT  = 3'd4,
        S_START = 3'd5
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_pending;
    logic              r_shuf_start;
    logic              r_rst_game_n;
    logic              r_start_timer;
    logic              r_ready;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_games;

    // A new game is wanted either by a fresh press or by one parked earlier.
    logic              w_req;
    assign w_req = newgame_i | r_pending;

    // Session FSM: every output is registered and set on the transition into
    // the state that owns it, so pulses line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BLOCK;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_shuf_start  <= 1'b0;
            r_rst_game_n  <= 1'b1;
            r_start_timer <= 1'b0;
            r_ready       <= 1'b0;
            r_timeout     <= 1'b0;
            r_games       <= '0;
        end else begin
            // Single-cycle strobes fall back to idle unless re-armed below.
            r_shuf_start  <= 1'b0;
            r_start_timer <= 1'b0;

            case (r_state)
                // Power-up input block; presses here are dropped, not parked.
                S_BLOCK: begin
                    if (r_cnt == c_BLOCK_LAST) begin
                        r_cnt <= '0;
                        if (BOOT_SHUFFLE != 0) begin
                            r_state      <= S_SHUF;
                            r_shuf_start <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Waiting for the player; a busy shuffler defers the request.
                S_IDLE: begin
                    if (w_req) begin
                        if (!shuf_busy_i) begin
                            r_state      <= S_SHUF;
                            r_shuf_start <= 1'b1;
                            r_pending    <= 1'b0;
                            r_ready      <= 1'b0;
                            r_cnt        <= '0;
                        end else begin
                            r_pending <= 1'b1;
                        end
                    end
                end

                // Shuffle in flight; done wins over the watchdog in a tie.
                S_SHUF: begin
                    if (newgame_i) begin
                        r_pending <= 1'b1;
                    end
                    if (shuf_done_i) begin
                        r_state      <= S_RST;
                        r_rst_game_n <= 1'b0;
                        r_cnt        <= '0;
                    end else if (r_cnt == c_TO_LAST) begin
                        // Give up on the shuffler; the old layout is kept.
                        r_timeout    <= 1'b1;
                        r_state      <= S_RST;
                        r_rst_game_n <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Soft reset held low to the game FSM and turn timer.
                S_RST: begin
                    if (newgame_i) begin
                        r_pending <= 1'b1;
                    end
                    if (r_cnt == c_RST_LAST) begin
                        r_cnt        <= '0;
                        r_rst_game_n <= 1'b1;
                        if (POST_RST_CYCLES == 0) begin
                            r_state       <= S_START;
                            r_start_timer <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Settle time after the soft reset before the timer starts.
                S_WAIT: begin
                    if (newgame_i) begin
                        r_pending <= 1'b1;
                    end
                    if (r_cnt == c_POST_LAST) begin
                        r_cnt         <= '0;
                        r_state       <= S_START;
                        r_start_timer <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Game launched; chain straight into a parked request if the
                // shuffler is free, otherwise keep it parked for IDLE.
                S_START: begin
                    if (r_games != c_GAMES_MAX) begin
                        r_games <= r_games + 1'b1;
                    end
                    r_cnt <= '0;
                    if (w_req && !shuf_busy_i) begin
                        r_state      <= S_SHUF;
                        r_shuf_start <= 1'b1;
                        r_pending    <= 1'b0;
                    end else begin
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b1;
                        r_pending <= w_req;
                    end
                end

                default: begin
                    r_state      <= S_BLOCK;
                    r_cnt        <= '0;
                    r_pending    <= 1'b0;
                    r_rst_game_n <= 1'b1;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    // Buttons pass only while the session is idle and ready for play.
    assign btn_pulse_o   = btn_pulse_i & {N_BTN{r_ready}};

    assign shuf_start_o  = r_shuf_start;
    assign rst_game_n_o  = r_rst_game_n;
    assign start_timer_o = r_start_timer;
    assign ready_o       = r_ready;
    assign timeout_o     = r_timeout;
    assign games_o       = r_games;

endmodule

`default_nettype wire

// File: tb/tb_game_session_seq.sv
// ============================================================================
// Module      : tb_game_session_seq
// Description : Self-checking bench for game_session_seq. Expected pulse
//               cycles are queued when stimulus is driven and popped by a
//               monitor when the DUT pulses; each scenario task also checks
//               levels inline every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_session_seq;

    logic       clk = 1'b0;
    logic       rst_n, newgame, busy, done;
    logic [1:0] btn_i;
    logic       shuf_start, rst_game_n, start_timer, ready, timeout;
    logic [1:0] btn_o;
    logic [7:0] games;

    logic       rst2_n, newgame2, busy2, done2;
    logic [1:0] btn2_i;
    logic       shuf_start2, rst_game2_n, start_timer2, ready2, timeout2;
    logic [1:0] btn2_o;
    logic [1:0] games2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    bit mon_en = 1'b0;
    int exp_shuf[$];
    int exp_tmr[$];
    int exp_games2[$];
    int mon_e;

    localparam int BIG = 1 << 30;

    game_session_seq #(
        .N_BTN(2), .BLOCK_CYCLES(8), .BOOT_SHUFFLE(1), .SOFT_RST_CYCLES(3),
        .POST_RST_CYCLES(2), .SHUF_TIMEOUT(16), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_pulse_i(btn_i), .newgame_i(newgame),
        .shuf_busy_i(busy), .shuf_done_i(done), .shuf_start_o(shuf_start),
        .rst_game_n_o(rst_game_n), .btn_pulse_o(btn_o), .start_timer_o(start_timer),
        .ready_o(ready), .timeout_o(timeout), .games_o(games)
    );

    game_session_seq #(
        .N_BTN(2), .BLOCK_CYCLES(8), .BOOT_SHUFFLE(1), .SOFT_RST_CYCLES(3),
        .POST_RST_CYCLES(2), .SHUF_TIMEOUT(16), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .btn_pulse_i(btn2_i), .newgame_i(newgame2),
        .shuf_busy_i(busy2), .shuf_done_i(done2), .shuf_start_o(shuf_start2),
        .rst_game_n_o(rst_game2_n), .btn_pulse_o(btn2_o), .start_timer_o(start_timer2),
        .ready_o(ready2), .timeout_o(timeout2), .games_o(games2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cnow();
        return cyc - rel;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int n);
        while (cnow() < n) step();
    endtask

    // Scoreboard monitor: every pulse must match the next queued cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (shuf_start === 1'b1) begin
                checks++;
                if (exp_shuf.size() == 0) begin
                    errors++;
                    $display("FAIL shuf_start: pulse at cycle %0d, required none", cnow());
                end else begin
                    mon_e = exp_shuf.pop_front();
                    if (cnow() !== mon_e) begin
                        errors++;
                        $display("FAIL shuf_start: pulse at cycle %0d, required %0d", cnow(), mon_e);
                    end
                end
            end
            if (start_timer === 1'b1) begin
                checks++;
                if (exp_tmr.size() == 0) begin
                    errors++;
                    $display("FAIL start_timer: pulse at cycle %0d, required none", cnow());
                end else begin
                    mon_e = exp_tmr.pop_front();
                    if (cnow() !== mon_e) begin
                        errors++;
                        $display("FAIL start_timer: pulse at cycle %0d, required %0d", cnow(), mon_e);
                    end
                end
            end
        end
    end

    // One new game from IDLE: newgame at k, done at d (d<0: never, watchdog).
    task automatic run_newgame(input int k, input int d, input int exp_g,
                               input logic [1:0] btn, input int to_from);
        int de;
        de = (d < 0) ? k + 16 : d;
        wait_cycle(k);
        exp_shuf.push_back(k + 1);
        exp_tmr.push_back(de + 6);
        for (int c = k; c <= de + 7; c++) begin
            newgame = (c == k);
            btn_i   = (c == k) ? btn : 2'b00;
            done    = (d >= 0) && (c == d);
            @(negedge clk);
            checks++;
            if (rst_game_n !== !(c > de && c <= de + 3)) begin
                errors++;
                $display("FAIL rst_game_n: cycle %0d got %b", c, rst_game_n);
            end
            checks++;
            if (ready !== (c == k || c == de + 7)) begin
                errors++;
                $display("FAIL ready: cycle %0d got %b", c, ready);
            end
            checks++;
            if (timeout !== (c >= to_from)) begin
                errors++;
                $display("FAIL timeout: cycle %0d got %b required %b", c, timeout, (c >= to_from));
            end
            if (c == k) begin
                checks++;
                if (btn_o !== btn) begin
                    errors++;
                    $display("FAIL btn_fwd: got %b required %b", btn_o, btn);
                end
            end
            if (c == de + 7) begin
                checks++;
                if (games !== 8'(exp_g)) begin
                    errors++;
                    $display("FAIL games: got %0d required %0d", games, exp_g);
                end
            end
            step();
        end
        newgame = 1'b0; btn_i = 2'b00; done = 1'b0;
        checks++;
        if (exp_shuf.size() != 0 || exp_tmr.size() != 0) begin
            errors++;
            $display("FAIL pulses_missing: shuf=%0d timer=%0d left", exp_shuf.size(), exp_tmr.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        btn_i = 2'b11; newgame = 1'b0; busy = 1'b0; done = 1'b0;
        btn2_i = 2'b00; newgame2 = 1'b0; busy2 = 1'b0; done2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({shuf_start, rst_game_n, start_timer, ready, timeout} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 01000",
                     {shuf_start, rst_game_n, start_timer, ready, timeout});
        end
        checks++;
        if (btn_o !== 2'b00 || games !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: btn_o=%b games=%0d required 0/0", btn_o, games);
        end
    endtask

    task automatic test_block();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        mon_en = 1'b1;
        exp_shuf.push_back(8);
        for (int c = 0; c < 8; c++) begin
            btn_i   = 2'b11;
            newgame = (c == 2 || c == 5);
            @(negedge clk);
            checks++;
            if (btn_o !== 2'b00 || ready !== 1'b0) begin
                errors++;
                $display("FAIL block_gate: cycle %0d btn_o=%b ready=%b required 00/0", c, btn_o, ready);
            end
            step();
        end
        btn_i = 2'b00; newgame = 1'b0;
    endtask

    task automatic test_boot_game();
        exp_tmr.push_back(18);
        for (int c = 8; c <= 19; c++) begin
            done = (c == 12);
            @(negedge clk);
            checks++;
            if (rst_game_n !== !(c >= 13 && c <= 15)) begin
                errors++;
                $display("FAIL boot_rst: cycle %0d got %b", c, rst_game_n);
            end
            checks++;
            if (ready !== (c == 19)) begin
                errors++;
                $display("FAIL boot_ready: cycle %0d got %b", c, ready);
            end
            if (c == 19) begin
                checks++;
                if (games !== 8'd1) begin
                    errors++;
                    $display("FAIL boot_games: got %0d required 1", games);
                end
            end
            step();
        end
        done = 1'b0;
        checks++;
        if (exp_shuf.size() != 0 || exp_tmr.size() != 0) begin
            errors++;
            $display("FAIL boot_pulses: shuf=%0d timer=%0d left", exp_shuf.size(), exp_tmr.size());
        end
    endtask

    task automatic test_idle_newgame();
        run_newgame(cnow() + 1, cnow() + 4, 2, 2'b01, BIG);
    endtask

    // Three presses during RST collapse into one chained shuffle.
    task automatic test_pending();
        int k;
        k = cnow() + 1;
        wait_cycle(k);
        exp_shuf.push_back(k + 1);
        exp_shuf.push_back(k + 10);
        exp_tmr.push_back(k + 9);
        exp_tmr.push_back(k + 18);
        for (int c = k; c <= k + 19; c++) begin
            newgame = (c == k) || (c >= k + 4 && c <= k + 6);
            done    = (c == k + 3) || (c == k + 12);
            @(negedge clk);
            checks++;
            if (ready !== (c == k || c == k + 19)) begin
                errors++;
                $display("FAIL pend_ready: cycle %0d got %b", c - k, ready);
            end
            checks++;
            if (rst_game_n !== !((c >= k + 4 && c <= k + 6) || (c >= k + 13 && c <= k + 15))) begin
                errors++;
                $display("FAIL pend_rst: cycle %0d got %b", c - k, rst_game_n);
            end
            if (c == k + 19) begin
                checks++;
                if (games !== 8'd4) begin
                    errors++;
                    $display("FAIL pend_games: got %0d required 4", games);
                end
            end
            step();
        end
        newgame = 1'b0; done = 1'b0;
        checks++;
        if (exp_shuf.size() != 0 || exp_tmr.size() != 0) begin
            errors++;
            $display("FAIL pend_pulses: shuf=%0d timer=%0d left", exp_shuf.size(), exp_tmr.size());
        end
    endtask

    // Press while the shuffler is busy is parked until busy drops; a stray
    // done in IDLE changes nothing.
    task automatic test_busy_pending();
        int k;
        k = cnow() + 1;
        wait_cycle(k);
        exp_shuf.push_back(k + 4);
        exp_tmr.push_back(k + 12);
        for (int c = k; c <= k + 13; c++) begin
            busy    = (c <= k + 2);
            newgame = (c == k);
            done    = (c == k + 1) || (c == k + 6);
            @(negedge clk);
            checks++;
            if (ready !== (c <= k + 3 || c == k + 13)) begin
                errors++;
                $display("FAIL busy_ready: cycle %0d got %b", c - k, ready);
            end
            if (c == k + 13) begin
                checks++;
                if (games !== 8'd5) begin
                    errors++;
                    $display("FAIL busy_games: got %0d required 5", games);
                end
            end
            step();
        end
        busy = 1'b0; newgame = 1'b0; done = 1'b0;
        checks++;
        if (exp_shuf.size() != 0 || exp_tmr.size() != 0) begin
            errors++;
            $display("FAIL busy_pulses: shuf=%0d timer=%0d left", exp_shuf.size(), exp_tmr.size());
        end
    endtask

    task automatic test_timeout();
        int k;
        k = cnow() + 1;
        run_newgame(k, -1, 6, 2'b00, k + 17);
        run_newgame(cnow() + 1, cnow() + 3, 7, 2'b10, 0);
    endtask

    task automatic test_saturate();
        int n;
        int e;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int g = 1; g <= 5; g++) begin
            exp_games2.push_back((g > 3) ? 3 : g);
            if (g > 1) begin
                newgame2 = 1'b1;
                @(posedge clk);
                #1;
                newgame2 = 1'b0;
            end
            n = 0;
            while (shuf_start2 !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                checks++; errors++;
                $display("FAIL sat_shuf_wait: game %0d no shuffle start", g);
            end
            done2 = 1'b1;
            @(posedge clk);
            #1;
            done2 = 1'b0;
            n = 0;
            while (start_timer2 !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                checks++; errors++;
                $display("FAIL sat_timer_wait: game %0d no timer start", g);
            end
            @(negedge clk);
            e = exp_games2.pop_front();
            checks++;
            if (games2 !== 2'(e) || ready2 !== 1'b1) begin
                errors++;
                $display("FAIL sat_games: game %0d got %0d ready=%b required %0d", g, games2, ready2, e);
            end
        end
    endtask

    // Global reset in WAIT: every output snaps back immediately.
    task automatic test_reset_wait();
        int k;
        k = cnow() + 1;
        wait_cycle(k);
        exp_shuf.push_back(k + 1);
        for (int c = k; c < k + 6; c++) begin
            newgame = (c == k);
            done    = (c == k + 2);
            step();
        end
        newgame = 1'b0; done = 1'b0;
        btn_i = 2'b11;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({shuf_start, rst_game_n, start_timer, ready, timeout} !== 5'b01000) begin
            errors++;
            $display("FAIL wait_rst_ctrl: got %b required 01000",
                     {shuf_start, rst_game_n, start_timer, ready, timeout});
        end
        checks++;
        if (btn_o !== 2'b00 || games !== 8'd0) begin
            errors++;
            $display("FAIL wait_rst_data: btn_o=%b games=%0d required 0/0", btn_o, games);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rst_game_n !== 1'b1 || start_timer !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_rst_hold: rst_game_n=%b start_timer=%b ready=%b",
                     rst_game_n, start_timer, ready);
        end
        checks++;
        if (exp_shuf.size() != 0 || exp_tmr.size() != 0) begin
            errors++;
            $display("FAIL wait_rst_pulses: shuf=%0d timer=%0d left", exp_shuf.size(), exp_tmr.size());
        end
        mon_en = 1'b0;
        btn_i = 2'b00;
    endtask

    initial begin
        test_reset();
        test_block();
        test_boot_game();
        test_idle_newgame();
        test_pending();
        test_busy_pending();
        test_timeout();
        test_saturate();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: run did not complete, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
